regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter BUS_SIZE, default 32, data width of the register file write port.
REQ-002 Parameter DIR_SIZE_INTERNAL, default 5, register address width (32 registers).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (rst=0 resets immediately; rst=1 runs).
REQ-005 aValid  input  1  writeback source A (ALU) offers a write.
REQ-006 aReady  output  1  arbiter accepts source A this cycle.
REQ-007 aDir  input  DIR_SIZE_INTERNAL  source A destination register.
REQ-008 aData  input  BUS_SIZE  source A write data.
REQ-009 bValid, bReady, bDir, bData: same widths and meanings as REQ-005..008, for source B (memory load).
REQ-010 enWrite  output  1  register file write enable, registered.
REQ-011 dirWrite  output  DIR_SIZE_INTERNAL  register file write address, registered.
REQ-012 writeData  output  BUS_SIZE  register file write data, registered.
REQ-013 grantB  output  1  registered; 1 when the current enWrite/drop cycle came from source B.
REQ-014 dropCount  output  8  registered count of requests targeting register 0 that were discarded; wraps 255->0.

Function
REQ-015 Each source has one holding entry: heldX flag, dir and data registers.
REQ-016 Handshake: transfer on rising edge when xValid=1 and xReady=1; data captured into the holding entry at that edge.
REQ-017 xReady = !heldX || grantX (combinational), so each source can sustain one transfer per cycle when granted every cycle.
REQ-018 Grant (combinational): only A held -> grant A; only B held -> grant B; both held -> grant the side selected by the priority bit prio (0=A, 1=B); none held -> no grant.
REQ-019 On each edge with a grant: prio <= opposite of the granted side; the granted entry is cleared unless a new transfer from the same source is captured at that edge (the entry is then reloaded).
REQ-020 On each edge with a grant whose dir != 0: enWrite<=1, dirWrite<=granted dir, writeData<=granted data, grantB<=(granted==B).
REQ-021 On each edge with a grant whose dir == 0: enWrite<=0, dirWrite/writeData hold, grantB<=(granted==B), dropCount<=dropCount+1 (mod 256).
REQ-022 On each edge with no grant: enWrite<=0; dirWrite, writeData, grantB hold.
REQ-023 Latency: transfer at edge N -> earliest enWrite=1 in the cycle after edge N+1; at most one write per cycle overall.
REQ-024 Same dir from both sources held simultaneously: both are written in grant order; the second write wins in the register file; no merging.
REQ-025 Valid with ready=0: source must hold dir/data stable; arbiter does not capture.
REQ-026 Ordering within one source is preserved (single entry, FIFO order trivially).

Reset
REQ-027 While rst=0: heldA=heldB=0, prio=0, enWrite=0, dirWrite=0, writeData=0, grantB=0, dropCount=0, aReady=bReady=1 (combinationally, since held flags are 0).
REQ-028 Reset asserted mid-operation discards both holding entries without issuing their writes; enWrite drops to 0 asynchronously.
REQ-029 First edge after rst returns to 1 behaves as normal operation, A favored on the first contention.

Verification
REQ-030 Reset then single A: rst=0 for 2 cycles, rst=1; aValid=1, aDir=5, aData=20 for one cycle -> next cycle heldA, following cycle enWrite=1, dirWrite=5, writeData=20, grantB=0 for exactly one cycle.
REQ-031 Contention: A (dir 12, data 3) and B (dir 7, data 9) transferred on the same edge after reset -> writes in consecutive cycles: dir 12/data 3 (grantB=0) then dir 7/data 9 (grantB=1); aReady=1 and bReady=0 during the first grant cycle.
REQ-032 Round-robin fairness: aValid=bValid=1 held continuously with changing data -> enWrite=1 every cycle after fill, grantB alternating 0,1,0,1; each source sees one transfer per two cycles.
REQ-033 Register 0: bValid=1, bDir=0, bData=0xFFFFFFFF -> no cycle with enWrite=1, dropCount increments 0->1, grantB=1 for the drop cycle; 256 such drops return dropCount to 0.
REQ-034 Same destination: A (dir 10, data 1) and B (dir 10, data 2) together with prio=1 -> write B then A; model register 10 ends at 1.
REQ-035 Reset mid-operation: both entries held, rst=0 asynchronously between edges -> enWrite=0 immediately, neither pending write appears after rst=1, aReady=bReady=1, dropCount=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Merges two register-file writeback sources into a single write port:
//   source A (ALU) and source B (memory load).
// Each source owns one holding entry (flag + dir + data). The held entries are
// arbitrated round-robin. Priority is only consulted when both entries are
// held, and it flips to the other side after every grant. The winning entry
// drives a registered write port. Writes aimed at register 0 are discarded and
// counted instead of being written.
//
// Handshake (both sources): a transfer happens on a rising clk edge where
// xValid=1 and xReady=1. The entry captures xDir/xData at that edge.
// xReady = !heldX || grantX, so an entry that is granted this cycle can be
// refilled at the same edge. While xValid=1 and xReady=0, the source must hold
// xDir/xData stable.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   aValid     A offers a write          aReady   A accepted this cycle
//   aDir       A destination register    aData    A write data
//   bValid     B offers a write          bReady   B accepted this cycle
//   bDir       B destination register    bData    B write data
//   enWrite    registered write enable
//   dirWrite   registered write address
//   writeData  registered write data
//   grantB     registered, 1 when the last write/drop came from B
//   dropCount  registered count of discarded register-0 writes (wraps)
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int BUS_SIZE          = 32,
  parameter int DIR_SIZE_INTERNAL = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         aValid,
  output logic                         aReady,
  input  logic [DIR_SIZE_INTERNAL-1:0] aDir,
  input  logic [BUS_SIZE-1:0]          aData,
  input  logic                         bValid,
  output logic                         bReady,
  input  logic [DIR_SIZE_INTERNAL-1:0] bDir,
  input  logic [BUS_SIZE-1:0]          bData,
  output logic                         enWrite,
  output logic [DIR_SIZE_INTERNAL-1:0] dirWrite,
  output logic [BUS_SIZE-1:0]          writeData,
  output logic                         grantB,
  output logic [7:0]                   dropCount
);

  // Holding entries
  logic                         held_a;
  logic                         held_b;
  logic [DIR_SIZE_INTERNAL-1:0] dir_a;
  logic [DIR_SIZE_INTERNAL-1:0] dir_b;
  logic [BUS_SIZE-1:0]          data_a;
  logic [BUS_SIZE-1:0]          data_b;

  // Round-robin pointer: 0 favours A, 1 favours B on contention
  logic prio;

  // Combinational grant and selected entry
  logic                         grant_a;
  logic                         grant_b;
  logic                         grant_any;
  logic [DIR_SIZE_INTERNAL-1:0] sel_dir;
  logic [BUS_SIZE-1:0]          sel_data;
  logic                         sel_is_zero;
  logic                         take_a;
  logic                         take_b;

  always_comb begin
    grant_a     = held_a && (!held_b || !prio);
    grant_b     = held_b && (!held_a ||  prio);
    grant_any   = grant_a || grant_b;
    sel_dir     = grant_b ? dir_b  : dir_a;
    sel_data    = grant_b ? data_b : data_a;
    sel_is_zero = (sel_dir == '0);
  end

  // A granted entry is released at this edge, so it can be refilled now
  assign aReady = !held_a || grant_a;
  assign bReady = !held_b || grant_b;
  assign take_a = aValid && aReady;
  assign take_b = bValid && bReady;

  // Source A holding entry. A new capture takes precedence over the release
  // caused by a grant, so the entry is reloaded rather than cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_a <= 1'b0;
      dir_a  <= '0;
      data_a <= '0;
    end else if (take_a) begin
      held_a <= 1'b1;
      dir_a  <= aDir;
      data_a <= aData;
    end else if (grant_a) begin
      held_a <= 1'b0;
    end
  end

  // Source B holding entry. The release/reload behaviour matches source A.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_b <= 1'b0;
      dir_b  <= '0;
      data_b <= '0;
    end else if (take_b) begin
      held_b <= 1'b1;
      dir_b  <= bDir;
      data_b <= bData;
    end else if (grant_b) begin
      held_b <= 1'b0;
    end
  end

  // Priority moves to the side that did not win the grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio <= 1'b0;
    end else if (grant_a) begin
      prio <= 1'b1;
    end else if (grant_b) begin
      prio <= 1'b0;
    end
  end

  // Registered write port. A register-0 grant still reports its source on
  // grantB, but it only bumps the drop counter and leaves the address and
  // data unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enWrite   <= 1'b0;
      dirWrite  <= '0;
      writeData <= '0;
      grantB    <= 1'b0;
      dropCount <= 8'd0;
    end else if (grant_any) begin
      grantB <= grant_b;
      if (sel_is_zero) begin
        enWrite   <= 1'b0;
        dropCount <= dropCount + 8'd1;
      end else begin
        enWrite   <= 1'b1;
        dirWrite  <= sel_dir;
        writeData <= sel_data;
      end
    end else begin
      enWrite <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Self-checking bench for regfile_wb_arbiter.
//
// A behavioural model tracks the pending write of each source as a queue of at
// most one item. It serves those queues round-robin and predicts the write
// port, the ready outputs and the drop counter. A compare process checks the
// DUT against the model on every falling edge. Directed scenarios add
// hand-computed literal checks, and randomized traffic follows them.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  localparam int BW = 32;
  localparam int DW = 5;

  // Clock / reset
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic          a_valid, b_valid;
  logic          a_ready, b_ready;
  logic [DW-1:0] a_dir, b_dir;
  logic [BW-1:0] a_data, b_data;
  logic          en_write;
  logic [DW-1:0] dir_write;
  logic [BW-1:0] write_data;
  logic          grant_b;
  logic [7:0]    drop_count;

  regfile_wb_arbiter #(.BUS_SIZE(BW), .DIR_SIZE_INTERNAL(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .aValid    (a_valid),
    .aReady    (a_ready),
    .aDir      (a_dir),
    .aData     (a_data),
    .bValid    (b_valid),
    .bReady    (b_ready),
    .bDir      (b_dir),
    .bData     (b_data),
    .enWrite   (en_write),
    .dirWrite  (dir_write),
    .writeData (write_data),
    .grantB    (grant_b),
    .dropCount (drop_count)
  );

  // Scoreboard counters
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: pending writes per source, round-robin favour bit,
  // expected registered outputs, and a model register file.
  logic [DW+BW-1:0] exp_qa[$];
  logic [DW+BW-1:0] exp_qb[$];
  logic             favor_b;
  logic             e_en;
  logic [DW-1:0]    e_dir;
  logic [BW-1:0]    e_data;
  logic             e_gb;
  logic [7:0]       e_drop;
  logic [BW-1:0]    model_rf[32];
  logic [BW-1:0]    dut_rf[32];

  initial begin
    for (int i = 0; i < 32; i++) begin
      model_rf[i] = '0;
      dut_rf[i]   = '0;
    end
  end

  // Compare process. Registered outputs are checked against the prediction
  // from the previous step. Ready is checked against the current pending
  // state. Then the model advances over the coming rising edge, using the
  // inputs, which stay stable from here to that edge.
  always @(negedge clk) begin : compare
    int               g;
    logic             ra, rb;
    logic [DW+BW-1:0] item;
    if (en_write === 1'b1) dut_rf[dir_write] = write_data;
    if (!rst) begin
      exp_qa.delete();
      exp_qb.delete();
      favor_b = 1'b0;
      e_en = 1'b0; e_dir = '0; e_data = '0; e_gb = 1'b0; e_drop = 8'd0;
      chk("rst_en",    en_write,   0);
      chk("rst_dir",   dir_write,  0);
      chk("rst_data",  write_data, 0);
      chk("rst_gb",    grant_b,    0);
      chk("rst_drop",  drop_count, 0);
      chk("rst_aready", a_ready,   1);
      chk("rst_bready", b_ready,   1);
    end else begin
      chk("en",   en_write,   e_en);
      chk("dir",  dir_write,  e_dir);
      chk("data", write_data, e_data);
      chk("gb",   grant_b,    e_gb);
      chk("drop", drop_count, e_drop);
      // Pick the source served at the next edge: 0 none, 1 A, 2 B
      if (exp_qa.size() != 0 && (exp_qb.size() == 0 || !favor_b)) g = 1;
      else if (exp_qb.size() != 0) g = 2;
      else g = 0;
      ra = (exp_qa.size() == 0) || (g == 1);
      rb = (exp_qb.size() == 0) || (g == 2);
      chk("aready", a_ready, ra);
      chk("bready", b_ready, rb);
      if (g != 0) begin
        item    = (g == 1) ? exp_qa.pop_front() : exp_qb.pop_front();
        favor_b = (g == 1);
        e_gb    = (g == 2);
        if (item[DW+BW-1:BW] != '0) begin
          e_en   = 1'b1;
          e_dir  = item[DW+BW-1:BW];
          e_data = item[BW-1:0];
          model_rf[item[DW+BW-1:BW]] = item[BW-1:0];
        end else begin
          e_en   = 1'b0;
          e_drop = e_drop + 8'd1;
        end
      end else begin
        e_en = 1'b0;
      end
      if (a_valid && ra) exp_qa.push_back({a_dir, a_data});
      if (b_valid && rb) exp_qb.push_back({b_dir, b_data});
    end
  end

  // Driver tasks. Inputs change 2 time units after each rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic idle(input int n);
    a_valid = 1'b0; b_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  logic ra_prev, rb_prev;

  initial begin : stimulus
    rst = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    a_dir = '0; b_dir = '0; a_data = '0; b_data = '0;
    tick();
    tick();
    chk("lit_reset_en",     en_write, 0);
    chk("lit_reset_aready", a_ready,  1);
    chk("lit_reset_bready", b_ready,  1);
    rst = 1'b1;

    // Single A write: transfer, then one cycle later a one-cycle write
    a_valid = 1'b1; a_dir = 5'd5; a_data = 32'd20;
    tick();
    a_valid = 1'b0;
    chk("lit_single_en_early", en_write, 0);
    tick();
    chk("lit_single_en",   en_write,   1);
    chk("lit_single_dir",  dir_write,  5);
    chk("lit_single_data", write_data, 20);
    chk("lit_single_gb",   grant_b,    0);
    tick();
    chk("lit_single_en_off", en_write, 0);
    idle(2);

    // Contention right after reset: A wins first
    do_reset();
    a_valid = 1'b1; a_dir = 5'd12; a_data = 32'd3;
    b_valid = 1'b1; b_dir = 5'd7;  b_data = 32'd9;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("lit_cont_aready", a_ready, 1);
    chk("lit_cont_bready", b_ready, 0);
    tick();
    chk("lit_cont1_en",   en_write,   1);
    chk("lit_cont1_dir",  dir_write,  12);
    chk("lit_cont1_data", write_data, 3);
    chk("lit_cont1_gb",   grant_b,    0);
    tick();
    chk("lit_cont2_en",   en_write,   1);
    chk("lit_cont2_dir",  dir_write,  7);
    chk("lit_cont2_data", write_data, 9);
    chk("lit_cont2_gb",   grant_b,    1);
    idle(2);

    // Fairness: both always valid, data changes only when accepted
    do_reset();
    a_valid = 1'b1; b_valid = 1'b1;
    a_dir = 5'd3; b_dir = 5'd4; a_data = 32'd100; b_data = 32'd200;
    for (int k = 1; k <= 12; k++) begin
      ra_prev = a_ready; rb_prev = b_ready;
      tick();
      if (k >= 2) begin
        chk("lit_rr_en", en_write, 1);
        chk("lit_rr_gb", grant_b,  (k % 2 == 1) ? 1 : 0);
      end
      if (ra_prev) a_data = a_data + 32'd1;
      if (rb_prev) b_data = b_data + 32'd1;
    end
    idle(3);

    // Register 0 drops from B: 256 drops wrap the counter back to 0
    do_reset();
    b_valid = 1'b1; b_dir = 5'd0; b_data = 32'hFFFF_FFFF;
    for (int k = 1; k <= 256; k++) begin
      tick();
      chk("lit_drop_no_write", en_write, 0);
      if (k == 2) begin
        chk("lit_drop_one", drop_count, 1);
        chk("lit_drop_gb",  grant_b,    1);
      end
    end
    b_valid = 1'b0;
    tick();
    chk("lit_drop_wrap", drop_count, 0);
    idle(2);

    // Same destination with priority on B: B is written first, A wins
    do_reset();
    a_valid = 1'b1; a_dir = 5'd1; a_data = 32'd7;
    tick();
    a_valid = 1'b0;
    tick();
    a_valid = 1'b1; a_dir = 5'd10; a_data = 32'd1;
    b_valid = 1'b1; b_dir = 5'd10; b_data = 32'd2;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    chk("lit_same1_gb",   grant_b,    1);
    chk("lit_same1_data", write_data, 2);
    tick();
    chk("lit_same2_gb",   grant_b,    0);
    chk("lit_same2_data", write_data, 1);
    tick();
    chk("lit_same_dut_rf10",   dut_rf[10],   1);
    chk("lit_same_model_rf10", model_rf[10], 1);
    idle(2);

    // Asynchronous reset while both entries are held and a write is out
    do_reset();
    a_valid = 1'b1; a_dir = 5'd21; a_data = 32'hA1;
    b_valid = 1'b1; b_dir = 5'd22; b_data = 32'hB1;
    tick();
    a_data = 32'hA2;
    tick();
    chk("lit_arst_pre_en", en_write, 1);
    #1;
    rst = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    #1;
    chk("lit_arst_en",     en_write,   0);
    chk("lit_arst_aready", a_ready,    1);
    chk("lit_arst_bready", b_ready,    1);
    chk("lit_arst_drop",   drop_count, 0);
    tick();
    tick();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("lit_arst_no_write", en_write, 0);
    end

    // Randomized traffic; offers are held stable until accepted
    a_valid = 1'b0; b_valid = 1'b0;
    ra_prev = 1'b1; rb_prev = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (!(a_valid && !ra_prev)) begin
        a_valid = ($urandom_range(0, 9) < 7);
        a_dir   = ($urandom_range(0, 7) == 0) ? 5'd0 : DW'($urandom_range(1, 31));
        a_data  = $urandom();
      end
      if (!(b_valid && !rb_prev)) begin
        b_valid = ($urandom_range(0, 9) < 6);
        b_dir   = ($urandom_range(0, 7) == 0) ? 5'd0 : DW'($urandom_range(1, 31));
        b_data  = $urandom();
      end
      ra_prev = a_ready;
      rb_prev = b_ready;
      tick();
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
